// File: rtl/lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : lsu_pkg
// Description : Shared types and helpers for the load/store controller:
//               access size encodings, FSM state enum, size-to-bytes helper.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Number of bytes covered by an access of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : lsu_load_ext
// Description : Combinational load extender. Keeps the low N bytes of the RAM
//               word and sign- or zero-extends them to 64 bits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [63:0] ext_o
);

  // Select the access width and fill the upper bits with zero or the sign bit.
  always_comb begin
    ext_o = data_i;
    case (size_i)
      SZ_B: ext_o = unsigned_i ? {56'd0, data_i[7:0]}  : {{56{data_i[7]}},  data_i[7:0]};
      SZ_H: ext_o = unsigned_i ? {48'd0, data_i[15:0]} : {{48{data_i[15]}}, data_i[15:0]};
      SZ_W: ext_o = unsigned_i ? {32'd0, data_i[31:0]} : {{32{data_i[31]}}, data_i[31:0]};
      default: ext_o = data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : lsu_mem_ctrl
// Description : Single-outstanding load/store controller for a 64-bit wide,
//               byte-addressed RAM. Sub-word stores are done as read-modify-
//               write because the RAM always writes all eight bytes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 5000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [63:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic        mem_wen_o,
  input  logic [63:0] mem_rdata_i
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] merged_q, merged_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [3:0]  req_n;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic [64:0] req_end;
  logic [3:0]  cur_n;
  logic [63:0] load_ext;
  logic [63:0] rmw_merged;

  // Request error check on the raw inputs; the end address is formed at 65 bits
  // so a request near the top of the 64-bit space cannot wrap into range.
  always_comb begin
    req_n            = size_bytes(req_size_i);
    req_misaligned   = |(req_addr_i[2:0] & (req_n[2:0] - 3'd1));
    req_end          = {1'b0, req_addr_i} + 65'd8;
    req_out_of_range = req_end > 65'(MEM_BYTES);
  end

  lsu_load_ext u_load_ext (
    .data_i     (mem_rdata_i),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .ext_o      (load_ext)
  );

  // Replace the low N byte lanes of the RAM word with the store data lanes.
  always_comb begin
    cur_n      = size_bytes(size_q);
    rmw_merged = mem_rdata_i;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < cur_n) begin
        rmw_merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  // Next-state and output decode; response registers only change when RESP is entered.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_addr_o   = 64'd0;
    mem_wdata_o  = 64'd0;
    mem_wen_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = !rst_i;
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (req_misaligned || req_out_of_range) begin
            rdata_d = 64'd0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (!req_we_i) begin
            state_d = ST_LOAD;
          end else if (req_size_i == SZ_D) begin
            merged_d = req_wdata_i;
            state_d  = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        mem_addr_o = addr_q;
        rdata_d    = load_ext;
        err_d      = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_addr_o = addr_q;
        merged_d   = rmw_merged;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        mem_addr_o  = addr_q;
        mem_wdata_o = merged_q;
        mem_wen_o   = !rst_i;
        rdata_d     = 64'd0;
        err_d       = 1'b0;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = !rst_i;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  // State and request/response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      merged_q <= 64'd0;
      rdata_q  <= 64'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire
